// File: rtl/trap_unit.sv
// Machine-mode trap controller: M-mode CSR file, exception/interrupt arbitration, trap entry and mret sequencing.
// Define TRAP_UNIT_COUNTERS_EN to add the 64-bit mcycle/minstret counters.
module trap_unit #(
  parameter int          NUM_IRQ     = 4,
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               inst_valid,
  input  logic               csr_rw,
  input  logic [1:0]         csr_wsc_mode,
  input  logic               csr_w_imm_mux,
  input  logic [11:0]        csr_addr,
  input  logic [31:0]        csr_w_data_reg,
  input  logic [4:0]         csr_w_data_imm,
  output logic [31:0]        csr_r_data,
  output logic               csr_illegal,
  input  logic               illegal_inst,
  input  logic               ecall_m,
  input  logic               l_access_fault,
  input  logic               s_access_fault,
  input  logic               mret,
  input  logic [31:0]        fault_addr,
  input  logic [31:0]        inst_ill,
  input  logic [31:0]        epc_cur,
  input  logic [31:0]        epc_next,
  output logic [31:0]        PC_redirect,
  output logic               redirect_mux,
  output logic               reg_FD_flush,
  output logic               reg_DE_flush,
  output logic               reg_EM_flush,
  output logic               reg_MW_flush,
  output logic               RegWrite_cancel
);

  localparam logic [31:0] MIE_MASK = (((32'h1 << NUM_IRQ) - 32'h1) << 16) | 32'h0000_0800;

  typedef enum logic [1:0] {IDLE, TRAP, RET} state_t;

  state_t      state;
  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic [31:0] mie_r;
  logic [31:0] mip_r;
  logic [31:0] mtvec_r;
  logic [31:0] mepc_r;
  logic [31:0] mcause_r;
  logic [31:0] mtval_r;
  logic [31:0] mscratch_r;

`ifdef TRAP_UNIT_COUNTERS_EN
  logic [63:0] mcycle_r;
  logic [63:0] minstret_r;
`endif

  logic [31:0] mstatus_rd;
  logic [31:0] csr_old;
  logic        csr_hit;
  logic [31:0] csr_operand;
  logic        csr_do_write;
  logic [31:0] csr_wdata;
  logic        csr_we;
  logic        exc_any;
  logic [31:0] exc_cause;
  logic [31:0] exc_tval;
  logic [31:0] pending;
  logic        irq_hit;
  logic [4:0]  irq_idx;
  logic [31:0] irq_code;
  logic        int_any;
  logic        trap_take;
  logic        mret_take;
  logic [31:0] trap_cause;
  logic [31:0] trap_tval;
  logic [31:0] trap_epc;
  logic [31:0] mtvec_base;
  logic [31:0] trap_target;
  logic [31:0] mip_next;

  assign mstatus_rd = 32'h0000_1800 | (32'(mstatus_mpie) << 7) | (32'(mstatus_mie) << 3);
  assign mip_next   = 32'(irq) << 16;

  always_comb begin
    csr_hit = 1'b1;
    csr_old = 32'h0;
    case (csr_addr)
      12'h300: csr_old = mstatus_rd;
      12'h304: csr_old = mie_r;
      12'h305: csr_old = mtvec_r;
      12'h340: csr_old = mscratch_r;
      12'h341: csr_old = mepc_r;
      12'h342: csr_old = mcause_r;
      12'h343: csr_old = mtval_r;
      12'h344: csr_old = mip_r;
`ifdef TRAP_UNIT_COUNTERS_EN
      12'hB00: csr_old = mcycle_r[31:0];
      12'hB80: csr_old = mcycle_r[63:32];
      12'hB02: csr_old = minstret_r[31:0];
      12'hB82: csr_old = minstret_r[63:32];
`endif
      default: csr_hit = 1'b0;
    endcase
  end

  // Set/clear with a zero operand index is a pure read.
  always_comb begin
    csr_operand  = csr_w_imm_mux ? {27'h0, csr_w_data_imm} : csr_w_data_reg;
    csr_do_write = (csr_wsc_mode == 2'b01) || (csr_wsc_mode[1] && (csr_w_data_imm != 5'd0));
    case (csr_wsc_mode)
      2'b01:   csr_wdata = csr_operand;
      2'b10:   csr_wdata = csr_old | csr_operand;
      2'b11:   csr_wdata = csr_old & ~csr_operand;
      default: csr_wdata = csr_old;
    endcase
  end

  always_comb begin
    exc_any   = inst_valid & (illegal_inst | ecall_m | l_access_fault | s_access_fault |
                              (csr_rw & ~csr_hit));
    exc_cause = 32'd0;
    exc_tval  = 32'h0;
    if (illegal_inst || (csr_rw && !csr_hit)) begin
      exc_cause = 32'd2;
      exc_tval  = inst_ill;
    end else if (ecall_m) begin
      exc_cause = 32'd11;
    end else if (l_access_fault) begin
      exc_cause = 32'd5;
      exc_tval  = fault_addr;
    end else if (s_access_fault) begin
      exc_cause = 32'd7;
      exc_tval  = fault_addr;
    end
  end

  // Scan from the top so the lowest pending line is the one left standing.
  always_comb begin
    pending = mip_r & mie_r;
    irq_hit = 1'b0;
    irq_idx = 5'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending[16+i]) begin
        irq_hit = 1'b1;
        irq_idx = 5'(i);
      end
    end
  end

  always_comb begin
    irq_code    = 32'd16 + 32'(irq_idx);
    int_any     = mstatus_mie & irq_hit & inst_valid & ~exc_any;
    trap_take   = ~rst & (state == IDLE) & (exc_any | int_any);
    mret_take   = ~rst & (state == IDLE) & inst_valid & mret & ~(exc_any | int_any);
    trap_cause  = exc_any ? exc_cause : {1'b1, irq_code[30:0]};
    trap_tval   = exc_any ? exc_tval : 32'h0;
    trap_epc    = exc_any ? epc_cur : epc_next;
    mtvec_base  = {mtvec_r[31:2], 2'b00};
    trap_target = ((mtvec_r[1:0] == 2'b01) && !exc_any) ? mtvec_base + (irq_code << 2) : mtvec_base;
    csr_we      = (state == IDLE) & inst_valid & csr_rw & csr_hit & csr_do_write & ~trap_take;
  end

  always_comb begin
    redirect_mux    = trap_take | mret_take;
    PC_redirect     = trap_take ? trap_target : (mret_take ? mepc_r : 32'h0);
    reg_FD_flush    = trap_take | mret_take;
    reg_DE_flush    = trap_take | mret_take;
    reg_EM_flush    = trap_take | mret_take;
    reg_MW_flush    = trap_take;
    RegWrite_cancel = trap_take & exc_any;
    csr_r_data      = rst ? 32'h0 : csr_old;
    csr_illegal     = ~rst & csr_rw & ~csr_hit;
  end

  // State and CSR update: trap entry beats mret, which beats a software write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_r        <= 32'h0;
      mip_r        <= 32'h0;
      mtvec_r      <= RESET_MTVEC;
      mepc_r       <= 32'h0;
      mcause_r     <= 32'h0;
      mtval_r      <= 32'h0;
      mscratch_r   <= 32'h0;
    end else begin
      mip_r <= mip_next;
      case (state)
        IDLE:    if (trap_take) state <= TRAP;
                 else if (mret_take) state <= RET;
        default: state <= IDLE;
      endcase
      if (trap_take) begin
        mepc_r       <= trap_epc & ~32'h3;
        mcause_r     <= trap_cause;
        mtval_r      <= trap_tval;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else if (mret_take) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end else if (csr_we) begin
        case (csr_addr)
          12'h300: begin
            mstatus_mie  <= csr_wdata[3];
            mstatus_mpie <= csr_wdata[7];
          end
          12'h304: mie_r      <= csr_wdata & MIE_MASK;
          12'h305: mtvec_r    <= csr_wdata[1] ? {csr_wdata[31:2], mtvec_r[1:0]} : csr_wdata;
          12'h340: mscratch_r <= csr_wdata;
          12'h341: mepc_r     <= csr_wdata & ~32'h3;
          12'h342: mcause_r   <= csr_wdata;
          12'h343: mtval_r    <= csr_wdata;
          default: ;
        endcase
      end
    end
  end

`ifdef TRAP_UNIT_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      mcycle_r   <= 64'h0;
      minstret_r <= 64'h0;
    end else begin
      if (csr_we && csr_addr == 12'hB00)      mcycle_r <= {mcycle_r[63:32], csr_wdata};
      else if (csr_we && csr_addr == 12'hB80) mcycle_r <= {csr_wdata, mcycle_r[31:0]};
      else                                    mcycle_r <= mcycle_r + 64'd1;
      if (csr_we && csr_addr == 12'hB02)      minstret_r <= {minstret_r[63:32], csr_wdata};
      else if (csr_we && csr_addr == 12'hB82) minstret_r <= {csr_wdata, minstret_r[31:0]};
      else if (inst_valid && !RegWrite_cancel && state == IDLE)
        minstret_r <= minstret_r + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_trap_unit.sv
// Scoreboard bench for trap_unit: stimulus pushes expected per-cycle outputs, a monitor pops and compares.
module tb_trap_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  irq;
  logic        inst_valid, csr_rw, csr_w_imm_mux;
  logic [1:0]  csr_wsc_mode;
  logic [11:0] csr_addr;
  logic [31:0] csr_w_data_reg;
  logic [4:0]  csr_w_data_imm;
  logic [31:0] csr_r_data;
  logic        csr_illegal;
  logic        illegal_inst, ecall_m, l_access_fault, s_access_fault, mret;
  logic [31:0] fault_addr, inst_ill, epc_cur, epc_next, PC_redirect;
  logic        redirect_mux, reg_FD_flush, reg_DE_flush, reg_EM_flush, reg_MW_flush;
  logic        RegWrite_cancel;

  trap_unit #(.NUM_IRQ(4), .RESET_MTVEC(32'h0)) dut (
    .clk(clk), .rst(rst), .irq(irq), .inst_valid(inst_valid), .csr_rw(csr_rw),
    .csr_wsc_mode(csr_wsc_mode), .csr_w_imm_mux(csr_w_imm_mux), .csr_addr(csr_addr),
    .csr_w_data_reg(csr_w_data_reg), .csr_w_data_imm(csr_w_data_imm),
    .csr_r_data(csr_r_data), .csr_illegal(csr_illegal), .illegal_inst(illegal_inst),
    .ecall_m(ecall_m), .l_access_fault(l_access_fault), .s_access_fault(s_access_fault),
    .mret(mret), .fault_addr(fault_addr), .inst_ill(inst_ill), .epc_cur(epc_cur),
    .epc_next(epc_next), .PC_redirect(PC_redirect), .redirect_mux(redirect_mux),
    .reg_FD_flush(reg_FD_flush), .reg_DE_flush(reg_DE_flush), .reg_EM_flush(reg_EM_flush),
    .reg_MW_flush(reg_MW_flush), .RegWrite_cancel(RegWrite_cancel)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rm;
    logic [31:0] pc;
    logic [3:0]  fl;
    logic        cancel;
    logic        ill;
    logic        chk_rd;
    logic [31:0] rd;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: one expectation per stimulus cycle, compared on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, ".redirect_mux"}, 32'(redirect_mux), 32'(e.rm));
        if (e.rm) chk({e.name, ".PC_redirect"}, PC_redirect, e.pc);
        chk({e.name, ".flush"}, 32'({reg_FD_flush, reg_DE_flush, reg_EM_flush, reg_MW_flush}),
            32'(e.fl));
        chk({e.name, ".RegWrite_cancel"}, 32'(RegWrite_cancel), 32'(e.cancel));
        chk({e.name, ".csr_illegal"}, 32'(csr_illegal), 32'(e.ill));
        if (e.chk_rd) chk({e.name, ".csr_r_data"}, csr_r_data, e.rd);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic clr();
    inst_valid = 0; csr_rw = 0; csr_wsc_mode = 2'b00; csr_w_imm_mux = 0; csr_addr = 12'h0;
    csr_w_data_reg = 32'h0; csr_w_data_imm = 5'd0; illegal_inst = 0; ecall_m = 0;
    l_access_fault = 0; s_access_fault = 0; mret = 0; fault_addr = 32'h0; inst_ill = 32'h0;
    epc_cur = 32'h0; epc_next = 32'h0;
  endtask

  task automatic issue(string name, logic rm, logic [31:0] pc, logic [3:0] fl, logic cancel,
                       logic ill, logic chk_rd, logic [31:0] rd);
    exp_t e;
    e.name = name; e.rm = rm; e.pc = pc; e.fl = fl; e.cancel = cancel;
    e.ill = ill; e.chk_rd = chk_rd; e.rd = rd;
    sb.push_back(e);
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic csr(string name, logic [11:0] a, logic [1:0] m, logic immx, logic [31:0] r,
                     logic [4:0] imm, logic [31:0] old);
    inst_valid = 1; csr_rw = 1; csr_addr = a; csr_wsc_mode = m; csr_w_imm_mux = immx;
    csr_w_data_reg = r; csr_w_data_imm = imm;
    issue(name, 0, 32'h0, 4'h0, 0, 0, 1, old);
  endtask

  task automatic rd(string name, logic [11:0] a, logic [31:0] exp);
    csr(name, a, 2'b10, 1'b0, 32'h0, 5'd0, exp);
  endtask

  task automatic nop(string name);
    issue(name, 0, 32'h0, 4'h0, 0, 0, 0, 32'h0);
  endtask

  initial begin
    clr();
    irq = 4'h0;
    rst = 1;
    @(posedge clk);
    #1;
    inst_valid = 1; ecall_m = 1; csr_rw = 1; csr_addr = 12'h7C0;
    issue("reset_outputs", 0, 32'h0, 4'h0, 0, 0, 1, 32'h0);
    rst = 0;

    rd("rst_mstatus", 12'h300, 32'h0000_1800);
    rd("rst_mtvec", 12'h305, 32'h0);
    csr("w_mtvec", 12'h305, 2'b01, 0, 32'h100, 5'd5, 32'h0);
    csr("set_mstatus_mie", 12'h300, 2'b10, 1, 32'h0, 5'd8, 32'h0000_1800);

    inst_valid = 1; ecall_m = 1; epc_cur = 32'h40; epc_next = 32'h44;
    issue("ecall", 1, 32'h100, 4'hF, 1, 0, 0, 32'h0);
    inst_valid = 1; mret = 1;
    issue("mret_in_trap", 0, 32'h0, 4'h0, 0, 0, 0, 32'h0);
    rd("ecall_mepc", 12'h341, 32'h40);
    rd("ecall_mcause", 12'h342, 32'd11);
    rd("ecall_mstatus", 12'h300, 32'h0000_1880);
    rd("ecall_mtval", 12'h343, 32'h0);

    csr("w_mepc", 12'h341, 2'b01, 0, 32'h44, 5'd5, 32'h40);
    inst_valid = 1; mret = 1;
    issue("mret", 1, 32'h44, 4'b1110, 0, 0, 0, 32'h0);
    inst_valid = 1; ecall_m = 1;
    issue("ecall_in_ret", 0, 32'h0, 4'h0, 0, 0, 0, 32'h0);
    rd("mret_mstatus", 12'h300, 32'h0000_1888);

    csr("w_mtvec_vec", 12'h305, 2'b01, 0, 32'h101, 5'd5, 32'h100);
    csr("set_mie17", 12'h304, 2'b10, 0, 32'h0002_0000, 5'd5, 32'h0);
    irq = 4'b0010;
    nop("irq1_sample");
    inst_valid = 1; epc_cur = 32'h7C; epc_next = 32'h80;
    issue("irq1_vectored", 1, 32'h144, 4'hF, 0, 0, 0, 32'h0);
    irq = 4'h0;
    nop("irq1_trap_state");
    rd("irq1_mcause", 12'h342, 32'h8000_0011);
    rd("irq1_mepc", 12'h341, 32'h80);
    rd("irq1_mtval", 12'h343, 32'h0);
    rd("irq1_mstatus", 12'h300, 32'h0000_1880);

    csr("w_mtvec_mode1x", 12'h305, 2'b01, 0, 32'h202, 5'd5, 32'h101);
    rd("mtvec_mode_kept", 12'h305, 32'h201);
    csr("set_mstatus_mie2", 12'h300, 2'b10, 1, 32'h0, 5'd8, 32'h0000_1880);
    csr("set_mie16_18", 12'h304, 2'b10, 0, 32'h0005_0000, 5'd5, 32'h0002_0000);
    irq = 4'b0101;
    nop("irq02_sample");
    inst_valid = 1; illegal_inst = 1; inst_ill = 32'hDEAD_BEEF; epc_cur = 32'h90; epc_next = 32'h94;
    issue("illegal_over_irq", 1, 32'h200, 4'hF, 1, 0, 0, 32'h0);
    nop("illegal_trap_state");
    rd("illegal_mcause", 12'h342, 32'd2);
    rd("illegal_mtval", 12'h343, 32'hDEAD_BEEF);
    rd("illegal_mepc", 12'h341, 32'h90);
    csr("set_mstatus_mie3", 12'h300, 2'b10, 1, 32'h0, 5'd8, 32'h0000_1880);
    inst_valid = 1; epc_cur = 32'hA0; epc_next = 32'hA4;
    issue("irq_lowest", 1, 32'h240, 4'hF, 0, 0, 0, 32'h0);
    irq = 4'h0;
    nop("irq0_trap_state");
    rd("irq0_mcause", 12'h342, 32'h8000_0010);
    rd("irq0_mepc", 12'h341, 32'hA4);

    csr("clr_idx0", 12'h300, 2'b11, 0, 32'hFFFF_FFFF, 5'd0, 32'h0000_1880);
    rd("clr_idx0_kept", 12'h300, 32'h0000_1880);

    inst_valid = 1; csr_rw = 1; csr_addr = 12'h7C0; csr_wsc_mode = 2'b01;
    csr_w_data_reg = 32'h55; csr_w_data_imm = 5'd5; inst_ill = 32'h1234_5678; epc_cur = 32'hB0;
    issue("csr_illegal", 1, 32'h200, 4'hF, 1, 1, 1, 32'h0);
    nop("csr_illegal_trap_state");
    rd("csr_illegal_mcause", 12'h342, 32'd2);
    rd("csr_illegal_mtval", 12'h343, 32'h1234_5678);
    rd("csr_illegal_mepc", 12'h341, 32'hB0);

    inst_valid = 1; ecall_m = 1; epc_cur = 32'hC0;
    issue("ecall_pre_rst", 1, 32'h200, 4'hF, 1, 0, 0, 32'h0);
    rst = 1;
    issue("rst_in_trap", 0, 32'h0, 4'h0, 0, 0, 0, 32'h0);
    rst = 0;
    inst_valid = 1;
    issue("post_rst_idle", 0, 32'h0, 4'h0, 0, 0, 0, 32'h0);
    rd("post_rst_mepc", 12'h341, 32'h0);
    rd("post_rst_mcause", 12'h342, 32'h0);
    rd("post_rst_mtvec", 12'h305, 32'h0);
    rd("post_rst_mstatus", 12'h300, 32'h0000_1800);

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
